// File: rtl/spi_flash_responder_if.sv
// Word-read port between the SPI flash responder and its backing memory.
interface spi_flash_responder_if #(
  parameter int ADDR_BITS = 24
);
  logic                 mem_ren;
  logic [ADDR_BITS-3:0] mem_raddr;
  logic [31:0]          mem_rdata;
  logic                 mem_rvalid;

  modport master (
    output mem_ren,
    output mem_raddr,
    input  mem_rdata,
    input  mem_rvalid
  );

  modport slave (
    input  mem_ren,
    input  mem_raddr,
    output mem_rdata,
    output mem_rvalid
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 NOR flash responder: READ 0x03, burst streaming from a word memory.
// Define FAST_READ_EN to also accept FAST_READ 0x0B with 8 dummy clocks.
module spi_flash_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 24
) (
  input  logic clock,
  input  logic reset,
  input  logic spi_sck,
  input  logic spi_ss,
  input  logic spi_mosi,
  output logic spi_miso,
  spi_flash_responder_if.master mem,
  output logic busy,
  output logic err_underrun
);
  localparam int CW = $clog2(ADDR_BITS);
  localparam logic [CW-1:0] LAST_A = CW'(ADDR_BITS - 1);
  localparam logic [CW-1:0] LAST_B = CW'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGN
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_s, r_ss_s, r_mosi_s;
  logic                   r_sck_q;
  state_t                 r_state, w_next;
  logic [CW-1:0]          r_bitcnt;
  logic [6:0]             r_cmd;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_fast, r_first, r_pend;
  logic [31:0]            r_buf, r_nxt;
  logic                   r_buf_vld, r_nxt_vld;
  logic [6:0]             r_obits;

  logic                   w_sck, w_ss, w_mosi, w_rise, w_fall;
  logic [7:0]             w_cmd;
  logic                   w_fast_cmd;
  logic [ADDR_BITS-1:0]   w_addr_in, w_addr_inc;
  logic                   w_bstart, w_load, w_src_vld;
  logic [31:0]            w_src;
  logic [7:0]             w_byte;
  logic                   w_first_fetch, w_fetch;
  logic [ADDR_BITS-3:0]   w_fetch_waddr;

  assign w_sck      = r_sck_s[SYNC_STAGES-1];
  assign w_ss       = r_ss_s[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
  assign w_rise     = w_sck & ~r_sck_q & ~w_ss;
  assign w_fall     = ~w_sck & r_sck_q & ~w_ss;
  assign w_cmd      = {r_cmd, w_mosi};
  assign w_addr_in  = {r_addr[ADDR_BITS-2:0], w_mosi};
  assign w_addr_inc = r_addr + 1'b1;
  assign busy       = ~w_ss;

`ifdef FAST_READ_EN
  assign w_fast_cmd = (w_cmd == 8'h0B);
`else
  assign w_fast_cmd = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sck_s  <= '0;
      r_ss_s   <= '1;
      r_mosi_s <= '0;
      r_sck_q  <= 1'b0;
    end else begin
      r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], spi_sck};
      r_ss_s   <= {r_ss_s[SYNC_STAGES-2:0], spi_ss};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_sck_q  <= w_sck;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_ss) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  w_next = S_CMD;
        S_CMD:
          if (w_rise && r_bitcnt == LAST_B)
            w_next = (w_cmd == 8'h03 || w_fast_cmd) ? S_ADDR : S_IGN;
        S_ADDR:
          if (w_rise && r_bitcnt == LAST_A)
            w_next = r_fast ? S_DUMMY : S_DATA;
        S_DUMMY:
          if (w_rise && r_bitcnt == LAST_B) w_next = S_DATA;
        default: w_next = r_state;
      endcase
    end
  end

  // The first byte of a burst always takes the freshly fetched word.
  always_comb begin
    w_bstart      = (r_state == S_DATA) && w_fall && (r_bitcnt == '0);
    w_load        = w_bstart && (r_first || r_addr[1:0] == 2'd0);
    w_src         = w_load ? r_nxt : r_buf;
    w_src_vld     = w_load ? r_nxt_vld : r_buf_vld;
    w_byte        = w_src[{r_addr[1:0], 3'b000} +: 8];
    w_first_fetch = (r_state == S_ADDR) && w_rise && (r_bitcnt == LAST_A);
    w_fetch       = w_first_fetch || (w_bstart && r_addr[1:0] == 2'd3);
    w_fetch_waddr = w_first_fetch ? w_addr_in[ADDR_BITS-1:2]
                                  : w_addr_inc[ADDR_BITS-1:2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spi_miso      <= 1'b0;
      mem.mem_ren   <= 1'b0;
      mem.mem_raddr <= '0;
      err_underrun  <= 1'b0;
      r_bitcnt      <= '0;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_fast        <= 1'b0;
      r_first       <= 1'b0;
      r_pend        <= 1'b0;
      r_buf         <= '0;
      r_nxt         <= '0;
      r_buf_vld     <= 1'b0;
      r_nxt_vld     <= 1'b0;
      r_obits       <= '0;
    end else begin
      mem.mem_ren <= w_fetch;
      if (w_fetch) mem.mem_raddr <= w_fetch_waddr;
      if (w_ss) begin
        spi_miso  <= 1'b0;
        r_bitcnt  <= '0;
        r_cmd     <= '0;
        r_addr    <= '0;
        r_fast    <= 1'b0;
        r_first   <= 1'b0;
        r_pend    <= 1'b0;
        r_buf_vld <= 1'b0;
        r_nxt_vld <= 1'b0;
        r_obits   <= '0;
      end else begin
        unique case (r_state)
          S_CMD: if (w_rise) begin
            r_cmd    <= w_cmd[6:0];
            r_bitcnt <= (r_bitcnt == LAST_B) ? '0 : r_bitcnt + 1'b1;
            if (r_bitcnt == LAST_B) r_fast <= w_fast_cmd;
          end
          S_ADDR: if (w_rise) begin
            r_addr   <= w_addr_in;
            r_bitcnt <= (r_bitcnt == LAST_A) ? '0 : r_bitcnt + 1'b1;
            if (r_bitcnt == LAST_A) r_first <= 1'b1;
          end
          S_DUMMY: if (w_rise)
            r_bitcnt <= (r_bitcnt == LAST_B) ? '0 : r_bitcnt + 1'b1;
          S_DATA: if (w_fall) begin
            if (w_bstart) begin
              spi_miso <= w_src_vld & w_byte[7];
              r_obits  <= w_src_vld ? w_byte[6:0] : 7'd0;
              r_first  <= 1'b0;
              if (!w_src_vld) err_underrun <= 1'b1;
              if (w_load) begin
                r_buf     <= r_nxt;
                r_buf_vld <= r_nxt_vld;
                r_nxt_vld <= 1'b0;
              end
            end else begin
              spi_miso <= r_obits[6];
              r_obits  <= {r_obits[5:0], 1'b0};
            end
            if (r_bitcnt == LAST_B) begin
              r_bitcnt <= '0;
              r_addr   <= w_addr_inc;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          default: ;
        endcase
        if (w_fetch) begin
          r_pend    <= 1'b1;
          r_nxt_vld <= 1'b0;
        end else if (r_pend && mem.mem_rvalid) begin
          r_nxt     <= mem.mem_rdata;
          r_nxt_vld <= 1'b1;
          r_pend    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed + randomized bench for spi_flash_responder against a byte-level
// flash model (memory contents, burst wrap, fetch list, underrun).
module tb_spi_flash_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_ss = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, busy, err_underrun;

  spi_flash_responder_if #(.ADDR_BITS(24)) m ();

  spi_flash_responder #(.SYNC_STAGES(2), .ADDR_BITS(24)) dut (
    .clock(clk), .reset(rst),
    .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .mem(m),
    .busy(busy), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

`ifdef FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;
  int half = 4;
  int hold_idx = -1;
  int inj_req = 0;
  int inj_done = 0;
  int rv_cnt = 0;
  logic [21:0] rv_addr = '0;
  logic [21:0] ren_log[$];
  logic rx[$];

  function automatic logic [31:0] mem_word(input logic [21:0] w);
    if (w == 22'h1000 || w == 22'h0) return 32'h44332211;
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [23:0] ba);
    logic [31:0] w;
    w = mem_word(ba[23:2]);
    return w[{ba[1:0], 3'b000} +: 8];
  endfunction

  // Memory: 1..2 cycle latency, one chosen request held off 20 cycles.
  always @(posedge clk) begin
    m.mem_rvalid <= 1'b0;
    if (m.mem_ren) begin
      rv_cnt = (ren_log.size() == hold_idx) ? 20 : int'($urandom_range(1, 2));
      rv_addr = m.mem_raddr;
      ren_log.push_back(m.mem_raddr);
    end
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        m.mem_rvalid <= 1'b1;
        m.mem_rdata  <= mem_word(rv_addr);
      end
    end else if (inj_req != inj_done) begin
      inj_done++;
      m.mem_rvalid <= 1'b1;
      m.mem_rdata  <= 32'hDEADBEEF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic mo, output logic mi);
    spi_mosi = mo;
    spi_sck  = 1'b0;
    repeat (half) @(negedge clk);
    mi = spi_miso;
    spi_sck = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] a,
                      input int nb, input int abort_at);
    int nbits;
    logic mi;
    logic [31:0] hdr;
    hdr = {cmd, a};
    nbits = 32 + ((cmd == 8'h0B) ? 8 : 0) + 8 * nb;
    rx.delete();
    spi_ss = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) break;
      clk_bit((i < 32) ? hdr[31-i] : 1'($urandom), mi);
      rx.push_back(mi);
    end
    chk("busy_active", 32'(busy), 32'd1);
    spi_ss = 1'b1;
    repeat (half) @(negedge clk);
    spi_sck = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_read(input string tag, input logic [7:0] cmd,
                            input logic [23:0] a, input int nb,
                            input int ren0, input bit uflow);
    bit acc;
    int lead, ones, nren;
    logic [7:0] got, want;
    logic [23:0] ba;
    logic [21:0] exp_ren[$];
    acc  = (cmd == 8'h03) || (FAST && cmd == 8'h0B);
    lead = 32 + ((cmd == 8'h0B) ? 8 : 0);
    ones = 0;
    for (int i = 0; i < lead; i++) ones += int'(rx[i]);
    chk($sformatf("%s_lead", tag), 32'(ones), 32'd0);
    if (acc) exp_ren.push_back(a[23:2]);
    for (int i = 0; i < nb; i++) begin
      ba = a + 24'(i);
      got = '0;
      for (int b = 0; b < 8; b++) got = {got[6:0], rx[lead + 8*i + b]};
      want = '0;
      if (acc && !(uflow && ba[23:2] == a[23:2])) want = exp_byte(ba);
      chk($sformatf("%s_b%0d", tag, i), 32'(got), 32'(want));
      if (acc && ba[1:0] == 2'd3) exp_ren.push_back(ba[23:2] + 22'd1);
    end
    nren = ren_log.size() - ren0;
    chk($sformatf("%s_nren", tag), 32'(nren), 32'(exp_ren.size()));
    for (int i = 0; i < exp_ren.size() && i < nren; i++)
      chk($sformatf("%s_ren%0d", tag, i), 32'(ren_log[ren0 + i]),
          32'(exp_ren[i]));
  endtask

  task automatic read_test(input string tag, input logic [7:0] cmd,
                           input logic [23:0] a, input int nb,
                           input bit uflow);
    int ren0;
    ren0 = ren_log.size();
    xfer(cmd, a, nb, -1);
    check_read(tag, cmd, a, nb, ren0, uflow);
  endtask

  initial begin
    int ren0;
    logic mi;
    logic [7:0] c;
    repeat (5) @(negedge clk);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_ren", 32'(m.mem_ren), 32'd0);
    chk("rst_raddr", 32'(m.mem_raddr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_underrun), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    read_test("basic", 8'h03, 24'h004000, 4, 1'b0);
    chk("basic_err", 32'(err_underrun), 32'd0);
    read_test("wrap", 8'h03, 24'hFFFFFE, 8, 1'b0);
    read_test("ign9f", 8'h9F, 24'($urandom), 1, 1'b0);
    read_test("after_ign", 8'h03, 24'($urandom), 3, 1'b0);

    ren0 = ren_log.size();
    xfer(8'h03, 24'h000123, 0, 20);
    chk("abort_nren", 32'(ren_log.size() - ren0), 32'd0);
    inj_req++;
    repeat (6) @(negedge clk);
    read_test("post_abort", 8'h03, 24'h000010, 4, 1'b0);

    for (int t = 0; t < 6; t++) begin
      half = int'($urandom_range(4, 7));
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h03;
      read_test($sformatf("rnd%0d", t), c, 24'($urandom),
                int'($urandom_range(1, 9)), 1'b0);
    end
    half = 5;
    read_test("fast0b", 8'h0B, 24'h000000, 1, 1'b0);
    chk("pre_uflow_err", 32'(err_underrun), 32'd0);

    half = 4;
    hold_idx = ren_log.size();
    read_test("uflow", 8'h03, 24'h000100, 8, 1'b1);
    chk("uflow_err", 32'(err_underrun), 32'd1);
    half = 6;
    read_test("post_uflow", 8'h03, 24'($urandom), 5, 1'b0);
    chk("err_sticky", 32'(err_underrun), 32'd1);

    spi_ss = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < 12; i++) clk_bit(1'($urandom), mi);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_miso", 32'(spi_miso), 32'd0);
    chk("mrst_ren", 32'(m.mem_ren), 32'd0);
    chk("mrst_raddr", 32'(m.mem_raddr), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_err", 32'(err_underrun), 32'd0);
    rst = 1'b0;
    spi_ss = 1'b1;
    spi_sck = 1'b0;
    repeat (8) @(negedge clk);
    read_test("post_rst", 8'h03, 24'h004002, 6, 1'b0);
    chk("post_rst_err", 32'(err_underrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
